// File: rtl/freq_meter.sv
// Period meter for a slow asynchronous square wave: reports each period in clk_ref cycles,
// flags tolerance and lock. Define FREQ_METER_HIGH_TIME_EN to also measure the high time.
module freq_meter #(
  parameter int CNT_W      = 16,
  parameter int EXPECT     = 100,
  parameter int TOL        = 2,
  parameter int LOCK_CNT   = 4,
  parameter int MAX_PERIOD = 1000
) (
  input  logic             clk_ref,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             in_tol,
  output logic             locked,
  output logic             timeout,
  output logic [CNT_W-1:0] high_out
);

  localparam int CW1   = CNT_W + 1;
  localparam int RUN_W = $clog2(LOCK_CNT + 1);
  // Bounds are held one bit wider so EXPECT+TOL cannot wrap; the lower bound clamps at 0.
  localparam logic [CNT_W:0]   LO_BOUND = (TOL > EXPECT) ? '0 : CW1'(EXPECT - TOL);
  localparam logic [CNT_W:0]   HI_BOUND = CW1'(EXPECT + TOL);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PERIOD);
  localparam logic [RUN_W-1:0] RUN_FULL = RUN_W'(LOCK_CNT);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           state, state_nxt;
  logic             s1, s2, s3;
  logic             rise;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] period_nxt;
  logic [RUN_W-1:0] run, run_nxt;
  logic             in_tol_nxt, valid_nxt, timeout_nxt;
  logic             cnt_ok;

  assign rise   = s2 & ~s3;
  assign cnt_ok = ({1'b0, cnt} >= LO_BOUND) && ({1'b0, cnt} <= HI_BOUND);
  assign locked = (run == RUN_FULL);

  // NOTE: every signal written here gets a default first, so no path leaves a value
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    run_nxt     = run;
    period_nxt  = period_out;
    in_tol_nxt  = in_tol;
    valid_nxt   = 1'b0;
    timeout_nxt = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      run_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            cnt_nxt   = CNT_W'(1);
            state_nxt = MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            // A rise on the timeout cycle still counts as a normal period.
            period_nxt = cnt;
            valid_nxt  = 1'b1;
            in_tol_nxt = cnt_ok;
            cnt_nxt    = CNT_W'(1);
            if (!cnt_ok)          run_nxt = '0;
            else if (run != RUN_FULL) run_nxt = run + RUN_W'(1);
          end else if (cnt == MAX_CNT) begin
            timeout_nxt = 1'b1;
            in_tol_nxt  = 1'b0;
            run_nxt     = '0;
            cnt_nxt     = '0;
            state_nxt   = IDLE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge value of its neighbours (the synchroniser chain depends on this).
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      state        <= IDLE;
      cnt          <= '0;
      run          <= '0;
      period_out   <= '0;
      in_tol       <= 1'b0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      s1           <= sig_in;
      s2           <= s1;
      s3           <= s2;
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      run          <= run_nxt;
      period_out   <= period_nxt;
      in_tol       <= in_tol_nxt;
      period_valid <= valid_nxt;
      timeout      <= timeout_nxt;
    end
  end

`ifdef FREQ_METER_HIGH_TIME_EN
  logic [CNT_W-1:0] high_cnt, high_cnt_nxt, high_nxt;

  // The rise cycle itself is high, so a restart loads 1 rather than 0.
  always_comb begin
    high_cnt_nxt = high_cnt;
    high_nxt     = high_out;
    if (!en) begin
      high_cnt_nxt = '0;
    end else if (state == IDLE) begin
      if (rise) high_cnt_nxt = CNT_W'(1);
    end else if (rise) begin
      high_nxt     = high_cnt;
      high_cnt_nxt = CNT_W'(1);
    end else if (cnt == MAX_CNT) begin
      high_cnt_nxt = '0;
    end else begin
      high_cnt_nxt = high_cnt + CNT_W'(s2);
    end
  end

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      high_cnt <= '0;
      high_out <= '0;
    end else begin
      high_cnt <= high_cnt_nxt;
      high_out <= high_nxt;
    end
  end
`else
  assign high_out = '0;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: table of periods, hand-written corner sequences
// (timeout, async reset, enable drop) and randomized periods against a period-level model.
module tb_freq_meter;

  localparam int CNT_W      = 16;
  localparam int EXPECT     = 100;
  localparam int TOL        = 2;
  localparam int LOCK_CNT   = 4;
  localparam int MAX_PERIOD = 1000;
`ifdef FREQ_METER_HIGH_TIME_EN
  localparam bit HIGH_EN = 1'b1;
`else
  localparam bit HIGH_EN = 1'b0;
`endif

  logic             clk_ref = 1'b0;
  logic             rst_n   = 1'b0;
  logic             en      = 1'b1;
  logic             sig_in  = 1'b0;
  logic [CNT_W-1:0] period_out;
  logic             period_valid;
  logic             in_tol;
  logic             locked;
  logic             timeout;
  logic [CNT_W-1:0] high_out;

  freq_meter #(
    .CNT_W(CNT_W), .EXPECT(EXPECT), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .MAX_PERIOD(MAX_PERIOD)
  ) dut (
    .clk_ref(clk_ref), .rst_n(rst_n), .en(en), .sig_in(sig_in),
    .period_out(period_out), .period_valid(period_valid), .in_tol(in_tol),
    .locked(locked), .timeout(timeout), .high_out(high_out)
  );

  always #5 clk_ref = ~clk_ref;

  typedef struct {
    int cyc;
    int period;
    int tol;
    int lock;
    int high;
  } rep_t;

  typedef struct {
    int period;
    int high;
    int exp_tol;
    int exp_lock;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   both_cnt = 0;
  rep_t rep_q[$];
  rep_t exp_q[$];
  int   to_q[$];
  int   rise_q[$];

  always @(posedge clk_ref) cyc++;

  always @(negedge clk_ref) begin
    if (rst_n && period_valid)
      rep_q.push_back('{cyc, int'(period_out), int'(in_tol), int'(locked), int'(high_out)});
    if (rst_n && timeout) to_q.push_back(cyc);
    if (period_valid && timeout) both_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected < 1000000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_ref);
  endtask

  task automatic pulse(input int p, input int h);
    rise_q.push_back(cyc);
    sig_in = 1'b1;
    tick(h);
    sig_in = 1'b0;
    tick(p - h);
  endtask

  task automatic final_rise();
    rise_q.push_back(cyc);
    sig_in = 1'b1;
    tick(50);
    sig_in = 1'b0;
    tick(10);
  endtask

  task automatic do_reset();
    @(negedge clk_ref);
    sig_in = 1'b0;
    en     = 1'b1;
    rst_n  = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    rep_q.delete();
    to_q.delete();
    rise_q.delete();
    exp_q.delete();
  endtask

  function automatic int high_exp(input int h);
    return HIGH_EN ? h : 0;
  endfunction

  function automatic int tol_ok(input int p);
    int lo;
    lo = (TOL > EXPECT) ? 0 : EXPECT - TOL;
    return (p >= lo && p <= EXPECT + TOL) ? 1 : 0;
  endfunction

  task automatic compare_reports(input string tag);
    check($sformatf("%s_count", tag), rep_q.size(), exp_q.size());
    for (int i = 0; i < rep_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_cyc[%0d]", tag, i), rep_q[i].cyc, exp_q[i].cyc);
      check($sformatf("%s_period[%0d]", tag, i), rep_q[i].period, exp_q[i].period);
      check($sformatf("%s_tol[%0d]", tag, i), rep_q[i].tol, exp_q[i].tol);
      check($sformatf("%s_lock[%0d]", tag, i), rep_q[i].lock, exp_q[i].lock);
      check($sformatf("%s_high[%0d]", tag, i), rep_q[i].high, exp_q[i].high);
    end
  endtask

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{100,  50, 1, 0};
    tbl[1]  = '{100,  50, 1, 0};
    tbl[2]  = '{100,  30, 1, 0};
    tbl[3]  = '{100,  70, 1, 1};
    tbl[4]  = '{110,  55, 0, 0};
    tbl[5]  = '{100,  50, 1, 0};
    tbl[6]  = '{100,  50, 1, 0};
    tbl[7]  = '{100,  50, 1, 0};
    tbl[8]  = '{100,  50, 1, 1};
    tbl[9]  = '{98,   49, 1, 1};
    tbl[10] = '{102,  51, 1, 1};
    tbl[11] = '{97,   10, 0, 0};
    tbl[12] = '{103,  90, 0, 0};
    tbl[13] = '{1000, 500, 0, 0};
    tbl[14] = '{100,  50, 1, 0};

    // Reset state
    tick(2);
    check("rst_period_out", period_out, 0);
    check("rst_period_valid", period_valid, 0);
    check("rst_in_tol", in_tol, 0);
    check("rst_locked", locked, 0);
    check("rst_timeout", timeout, 0);
    check("rst_high_out", high_out, 0);

    // Table: first rise arms, each later rise reports the preceding period
    do_reset();
    for (int i = 0; i < 15; i++) pulse(tbl[i].period, tbl[i].high);
    final_rise();
    for (int i = 0; i < 15; i++)
      exp_q.push_back('{rise_q[i+1] + 3, tbl[i].period, tbl[i].exp_tol, tbl[i].exp_lock,
                        high_exp(tbl[i].high)});
    compare_reports("tbl");
    check("tbl_no_timeout", to_q.size(), 0);

    // Lock, then signal stuck low -> one timeout 1000 cycles after the restart
    do_reset();
    for (int i = 0; i < 5; i++) pulse(100, 50);
    tick(1000);
    check("to_reports", rep_q.size(), 4);
    if (rep_q.size() == 4) check("to_locked_before", rep_q[3].lock, 1);
    check("to_count", to_q.size(), 1);
    if (to_q.size() >= 1 && rep_q.size() >= 4) check("to_cyc", to_q[0], rep_q[3].cyc + 1000);
    check("to_locked_after", locked, 0);
    check("to_in_tol_after", in_tol, 0);
    check("to_period_hold", period_out, 100);
    pulse(100, 50);
    check("to_arm_only", rep_q.size(), 4);
    final_rise();
    check("to_rearm_reports", rep_q.size(), 5);
    if (rep_q.size() == 5) begin
      check("to_rearm_period", rep_q[4].period, 100);
      check("to_rearm_cyc", rep_q[4].cyc, rise_q[rise_q.size()-1] + 3);
    end
    check("to_single_pulse", to_q.size(), 1);

    // Async reset mid-period
    do_reset();
    for (int i = 0; i < 5; i++) pulse(100, 50);
    sig_in = 1'b1;
    tick(20);
    check("ar_locked_before", locked, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_period_out", period_out, 0);
    check("ar_in_tol", in_tol, 0);
    check("ar_locked", locked, 0);
    check("ar_valid", period_valid, 0);
    check("ar_high_out", high_out, 0);
    @(negedge clk_ref);
    sig_in = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    rep_q.delete();
    rise_q.delete();
    pulse(100, 50);
    pulse(100, 50);
    final_rise();
    exp_q.delete();
    exp_q.push_back('{rise_q[1] + 3, 100, 1, 0, high_exp(50)});
    exp_q.push_back('{rise_q[2] + 3, 100, 1, 0, high_exp(50)});
    compare_reports("ar");

    // Enable dropped for 300 cycles during lock
    do_reset();
    for (int i = 0; i < 5; i++) pulse(100, 50);
    check("en_locked_before", locked, 1);
    en = 1'b0;
    tick(5);
    check("en_locked_low", locked, 0);
    check("en_period_hold", period_out, 100);
    check("en_in_tol_hold", in_tol, 1);
    tick(95);
    pulse(100, 50);
    pulse(100, 50);
    check("en_no_reports", rep_q.size(), 4);
    check("en_no_timeouts", to_q.size(), 0);
    en = 1'b1;
    begin
      int base;
      base = rise_q.size();
      pulse(100, 50);
      check("en_arm_only", rep_q.size(), 4);
      final_rise();
      check("en_resume_reports", rep_q.size(), 5);
      if (rep_q.size() == 5) begin
        check("en_resume_period", rep_q[4].period, 100);
        check("en_resume_cyc", rep_q[4].cyc, rise_q[base+1] + 3);
        check("en_resume_lock", rep_q[4].lock, 0);
      end
    end

    // Randomized periods against a period-level model
    do_reset();
    begin
      int per[20];
      int hi[20];
      int run;
      for (int i = 0; i < 20; i++) begin
        per[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 140))
                                              : int'($urandom_range(96, 104));
        hi[i]  = $urandom_range(1, per[i] - 1);
        pulse(per[i], hi[i]);
      end
      final_rise();
      run = 0;
      for (int i = 0; i < 20; i++) begin
        if (tol_ok(per[i]) == 1) run = (run < LOCK_CNT) ? run + 1 : run;
        else run = 0;
        exp_q.push_back('{rise_q[i+1] + 3, per[i], tol_ok(per[i]),
                          (run == LOCK_CNT) ? 1 : 0, high_exp(hi[i])});
      end
    end
    compare_reports("rnd");
    check("rnd_no_timeout", to_q.size(), 0);

    check("valid_timeout_exclusive", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
